// File: rtl/wide_uart_host.sv
// Wide-UART initiator: sends control + WIDTH payload bytes, then collects status + WIDTH reply bytes.
// Define WIDE_UART_HOST_PARITY_EN for 8E1 framing in both directions (default 8N1).
module wide_uart_host #(
  parameter int unsigned CLOCK_SCALE = 26,
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned TIMEOUT     = 1200000
) (
  input  logic                 masterClock,
  input  logic                 reset,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 start,
  input  logic [7:0]           control,
  input  logic [8*WIDTH-1:0]   outputData,
  output logic                 busy,
  output logic [7:0]           status,
  output logic [8*WIDTH-1:0]   inputData,
  output logic                 responseValid,
  output logic                 timeout,
  output logic                 frameError
);

  localparam int unsigned BIT_CLKS = 4 * CLOCK_SCALE;
`ifdef WIDE_UART_HOST_PARITY_EN
  localparam int unsigned BITS = 11;
`else
  localparam int unsigned BITS = 10;
`endif
  localparam int unsigned FW = 8 * (WIDTH + 1);
  localparam int unsigned CW = $clog2(BIT_CLKS);
  localparam int unsigned BW = $clog2(BITS);
  localparam int unsigned YW = $clog2(WIDTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_RECV} state_t;

  state_t               r_state, w_next;
  logic [CW-1:0]        r_clk_cnt;
  logic [BW-1:0]        r_bit_idx;
  logic [YW-1:0]        r_byte_idx;
  logic [TW-1:0]        r_to_cnt;
  logic [FW-1:0]        r_tx_buf;
  logic [7:0]           r_rx_sh;
  logic [7:0]           r_status_sh, r_status;
  logic [8*WIDTH-1:0]   r_data_sh, r_data;
  logic                 r_rx_s1, r_rx_s2, r_rx_prev;
  logic                 r_resp_valid, r_timeout, r_frame_err;
`ifdef WIDE_UART_HOST_PARITY_EN
  logic                 r_par_err;
`endif

  logic       w_rx, w_fall, w_bit_end, w_half, w_last_bit, w_last_byte, w_to, w_accept, w_stop_ok;
  logic [7:0] w_cur;

  assign w_rx        = r_rx_s2;
  assign w_fall      = r_rx_prev & ~r_rx_s2;
  assign w_bit_end   = (r_clk_cnt == CW'(BIT_CLKS - 1));
  assign w_half      = (r_clk_cnt == CW'(2 * CLOCK_SCALE - 1));
  assign w_last_bit  = (r_bit_idx == BW'(BITS - 1));
  assign w_last_byte = (r_byte_idx == YW'(WIDTH));
  assign w_to        = (r_to_cnt == TW'(TIMEOUT - 1));
  assign w_accept    = start & (r_state == S_IDLE) & ~r_resp_valid;
  assign w_cur       = r_tx_buf[FW-1 -: 8];
`ifdef WIDE_UART_HOST_PARITY_EN
  assign w_stop_ok   = w_rx & ~r_par_err;
`else
  assign w_stop_ok   = w_rx;
`endif

  assign status        = r_status;
  assign inputData     = r_data;
  assign responseValid = r_resp_valid;
  assign timeout       = r_timeout;
  assign frameError    = r_frame_err;

  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_SEND;
      S_SEND: if (w_bit_end && w_last_bit && w_last_byte) w_next = S_WAIT;
      S_WAIT: begin
        if (w_to)        w_next = S_IDLE;
        else if (w_fall) w_next = S_RECV;
      end
      S_RECV: begin
        if (r_bit_idx == '0) begin
          if (w_half && w_rx) w_next = S_WAIT;
        end else if (w_bit_end && w_last_bit) begin
          w_next = (w_stop_ok && !w_last_byte) ? S_WAIT : S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
    tx   = 1'b1;
    if (r_state == S_SEND) begin
      if (r_bit_idx == '0)            tx = 1'b0;
      else if (r_bit_idx <= BW'(8))   tx = w_cur[3'(r_bit_idx - 1'b1)];
`ifdef WIDE_UART_HOST_PARITY_EN
      else if (r_bit_idx == BW'(9))   tx = ^w_cur;
`endif
    end
  end

  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) begin
      r_clk_cnt    <= '0;
      r_bit_idx    <= '0;
      r_byte_idx   <= '0;
      r_to_cnt     <= '0;
      r_tx_buf     <= '0;
      r_rx_sh      <= '0;
      r_status_sh  <= '0;
      r_data_sh    <= '0;
      r_status     <= '0;
      r_data       <= '0;
      r_resp_valid <= 1'b0;
      r_timeout    <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef WIDE_UART_HOST_PARITY_EN
      r_par_err    <= 1'b0;
`endif
    end else begin
      r_resp_valid <= 1'b0;
      r_timeout    <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_clk_cnt  <= '0;
          r_bit_idx  <= '0;
          r_byte_idx <= '0;
          if (w_accept) r_tx_buf <= {control, outputData};
        end
        S_SEND: begin
          r_to_cnt  <= '0;
          r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + 1'b1;
          if (w_bit_end) begin
            if (w_last_bit) begin
              r_bit_idx  <= '0;
              r_byte_idx <= w_last_byte ? '0 : r_byte_idx + 1'b1;
              r_tx_buf   <= r_tx_buf << 8;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end
        S_WAIT: begin
          r_clk_cnt <= '0;
          r_bit_idx <= '0;
          if (!w_to) r_to_cnt  <= r_to_cnt + 1'b1;
          else       r_timeout <= 1'b1;
        end
        S_RECV: begin
          // timeout keeps running through a byte so a glitch-return to WAIT resumes the count
          if (!w_to) r_to_cnt <= r_to_cnt + 1'b1;
          r_clk_cnt <= (w_bit_end || (r_bit_idx == '0 && w_half)) ? '0 : r_clk_cnt + 1'b1;
          if (r_bit_idx == '0) begin
            if (w_half && !w_rx) r_bit_idx <= BW'(1);
          end else if (w_bit_end) begin
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx <= BW'(8)) r_rx_sh <= {w_rx, r_rx_sh[7:1]};
`ifdef WIDE_UART_HOST_PARITY_EN
            if (r_bit_idx == BW'(9)) r_par_err <= w_rx ^ (^r_rx_sh);
`endif
            if (w_last_bit) begin
              r_bit_idx <= '0;
              if (w_stop_ok) begin
                r_to_cnt <= '0;
                if (r_byte_idx == '0) r_status_sh <= r_rx_sh;
                else                  r_data_sh   <= {r_data_sh[8*WIDTH-9:0], r_rx_sh};
                if (w_last_byte) begin
                  r_status     <= r_status_sh;
                  r_data       <= {r_data_sh[8*WIDTH-9:0], r_rx_sh};
                  r_resp_valid <= 1'b1;
                  r_byte_idx   <= '0;
                end else begin
                  r_byte_idx <= r_byte_idx + 1'b1;
                end
              end else begin
                r_frame_err <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_uart_host.sv
// Scoreboard bench for wide_uart_host: decodes tx frames, plays a peer on rx, checks pulses and results.
module tb_wide_uart_host;
  localparam int CS = 26;
  localparam int W  = 5;
  localparam int TO = 3000;
  localparam int BC = 4 * CS;
`ifdef WIDE_UART_HOST_PARITY_EN
  localparam int BITS = 11;
`else
  localparam int BITS = 10;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           rx = 1'b1;
  logic           start = 1'b0;
  logic [7:0]     control = '0;
  logic [8*W-1:0] outputData = '0;
  logic           tx, busy, rv, to, fe;
  logic [7:0]     status;
  logic [8*W-1:0] inputData;

  int vectors = 0;
  int miscompares = 0;
  int n_rv = 0, n_to = 0, n_fe = 0;
  logic [7:0]     exp_tx_q[$];
  logic [8*W+7:0] exp_rsp_q[$];
  logic [8*W+7:0] m_exp;

  wide_uart_host #(.CLOCK_SCALE(CS), .WIDTH(W), .TIMEOUT(TO)) dut (
    .masterClock(clk), .reset(rst_n), .rx(rx), .tx(tx), .start(start),
    .control(control), .outputData(outputData), .busy(busy), .status(status),
    .inputData(inputData), .responseValid(rv), .timeout(to), .frameError(fe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rv) begin
      n_rv++;
      vectors++;
      if (exp_rsp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rsp_unexpected got status=%h data=%h required no response", status, inputData);
      end else begin
        m_exp = exp_rsp_q.pop_front();
        if ({status, inputData} !== m_exp || busy !== 1'b0) begin
          miscompares++;
          $display("FAIL rsp got status=%h data=%h busy=%b required %h busy=0", status, inputData, busy, m_exp);
        end
      end
    end
    if (to) n_to++;
    if (fe) n_fe++;
  end

  task automatic send_frame(input logic [7:0] c, input logic [8*W-1:0] d, input bit poke);
    logic [BITS-1:0] sh, eb;
    logic [7:0] ev;
    bit bad_busy;
    int rest;
    exp_tx_q.push_back(c);
    for (int i = 0; i < W; i++) exp_tx_q.push_back(d[8*(W-1-i) +: 8]);
    @(negedge clk);
    control = c; outputData = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0; control = '0; outputData = '0;
    vectors++;
    if (busy !== 1'b1 || tx !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_launch got busy=%b tx=%b required busy=1 tx=0", busy, tx);
    end
    bad_busy = 1'b0;
    for (int by = 0; by <= W; by++) begin
      for (int b = 0; b < BITS; b++) begin
        repeat (BC/2) @(negedge clk);
        sh[b] = tx;
        if (busy !== 1'b1) bad_busy = 1'b1;
        rest = BC/2;
        if (poke && by == 2 && b == 3) begin
          start = 1'b1; control = 8'hFF; outputData = '1;
          @(negedge clk);
          start = 1'b0; control = '0; outputData = '0;
          rest--;
        end
        repeat (rest) @(negedge clk);
      end
      ev = (exp_tx_q.size() != 0) ? exp_tx_q.pop_front() : 8'hxx;
`ifdef WIDE_UART_HOST_PARITY_EN
      eb = {1'b1, ^ev, ev, 1'b0};
`else
      eb = {1'b1, ev, 1'b0};
`endif
      vectors++;
      if (sh !== eb) begin
        miscompares++;
        $display("FAIL tx_byte%0d got bits=%b required %b", by, sh, eb);
      end
    end
    vectors++;
    if (bad_busy || busy !== 1'b1 || tx !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_end got busy_drop=%b busy=%b tx=%b required 0,1,1", bad_busy, busy, tx);
    end
  endtask

  // mode: 0 good, 1 stop bit low, 2 wrong parity
  task automatic send_byte(input logic [7:0] b, input int mode);
    rx = 1'b0;
    repeat (BC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BC) @(negedge clk);
    end
`ifdef WIDE_UART_HOST_PARITY_EN
    rx = (^b) ^ (mode == 2);
    repeat (BC) @(negedge clk);
`endif
    rx = (mode != 1);
    repeat (BC) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic peer_reply(input logic [7:0] st, input logic [8*W-1:0] d, input int bad_idx, input int mode);
    for (int i = 0; i <= W; i++)
      send_byte((i == 0) ? st : d[8*(W-i) +: 8], (i == bad_idx) ? mode : 0);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b0 || status !== 8'h00 || inputData !== '0 || rv !== 1'b0 || to !== 1'b0 || fe !== 1'b0) begin
      miscompares++;
      $display("FAIL reset got tx=%b busy=%b st=%h data=%h pulses=%b%b%b required 1,0,00,0,000",
               tx, busy, status, inputData, rv, to, fe);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_response;
    int rv0, n;
    rv0 = n_rv;
    send_frame(8'hA5, 40'h0102030405, 1'b0);
    exp_rsp_q.push_back({8'h3C, 40'h1122334455});
    fork
      peer_reply(8'h3C, 40'h1122334455, -1, 0);
      begin
        n = 0;
        while (rv !== 1'b1 && n < 10000) begin @(negedge clk); n++; end
        start = 1'b1; control = 8'h77;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (n >= 10000 || busy !== 1'b0) begin
          miscompares++;
          $display("FAIL start_in_rv_cycle got wait=%0d busy=%b required response and busy=0", n, busy);
        end
      end
    join
    vectors++;
    if (n_rv != rv0 + 1) begin
      miscompares++;
      $display("FAIL rv_count got %0d required %0d", n_rv - rv0, 1);
    end
  endtask

  task automatic test_timeout;
    int n, rv0;
    rv0 = n_rv;
    send_frame(8'hC3, 40'hDEADBEEF01, 1'b0);
    n = 0;
    while (to !== 1'b1 && n < 2*TO) begin @(negedge clk); n++; end
    vectors++;
    if (n != TO || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout got delay=%0d busy=%b required %0d busy=0", n, busy, TO);
    end
    vectors++;
    if (status !== 8'h3C || inputData !== 40'h1122334455 || n_rv != rv0) begin
      miscompares++;
      $display("FAIL timeout_hold got st=%h data=%h required 3c 1122334455", status, inputData);
    end
  endtask

  task automatic test_frame_error;
    int fe0, rv0, n;
    fe0 = n_fe; rv0 = n_rv;
    send_frame(8'h5A, 40'h0A0B0C0D0E, 1'b0);
    fork
      peer_reply(8'h77, 40'h9988776655, 2, 1);
      begin
        n = 0;
        while (fe !== 1'b1 && n < 10000) begin @(negedge clk); n++; end
        vectors++;
        if (n >= 10000 || busy !== 1'b0 || status !== 8'h3C || inputData !== 40'h1122334455) begin
          miscompares++;
          $display("FAIL frame_error got wait=%0d busy=%b st=%h data=%h required pulse busy=0 3c 1122334455",
                   n, busy, status, inputData);
        end
      end
    join
    vectors++;
    if (n_fe != fe0 + 1 || n_rv != rv0) begin
      miscompares++;
      $display("FAIL fe_count got fe=%0d rv=%0d required 1 0", n_fe - fe0, n_rv - rv0);
    end
  endtask

  task automatic test_glitch;
    int fe0, rv0, to0;
    fe0 = n_fe; rv0 = n_rv; to0 = n_to;
    send_frame(8'h11, 40'hF0E1D2C3B4, 1'b0);
    repeat (100) @(negedge clk);
    rx = 1'b0;
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    exp_rsp_q.push_back({8'hE7, 40'h8040201008});
    peer_reply(8'hE7, 40'h8040201008, -1, 0);
    repeat (10) @(negedge clk);
    vectors++;
    if (n_rv != rv0 + 1 || n_fe != fe0 || n_to != to0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch got rv=%0d fe=%0d to=%0d busy=%b required 1 0 0 0",
               n_rv - rv0, n_fe - fe0, n_to - to0, busy);
    end
  endtask

  task automatic test_reset_abort;
    int n, to0;
    @(negedge clk);
    control = 8'h3E; outputData = 40'h123456789A; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3*BITS*BC + 300) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b0 || status !== 8'h00 || inputData !== '0) begin
      miscompares++;
      $display("FAIL reset_abort got tx=%b busy=%b st=%h data=%h required 1 0 00 0", tx, busy, status, inputData);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    to0 = n_to;
    send_frame(8'h96, 40'h6655443322, 1'b1);
    n = 0;
    while (to !== 1'b1 && n < 2*TO) begin @(negedge clk); n++; end
    @(negedge clk);
    vectors++;
    if (n_to != to0 + 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL post_abort_timeout got to=%0d busy=%b required 1 0", n_to - to0, busy);
    end
  endtask

`ifdef WIDE_UART_HOST_PARITY_EN
  task automatic test_parity;
    int fe0, rv0;
    fe0 = n_fe; rv0 = n_rv;
    send_frame(8'h01, 40'h0000000003, 1'b0);
    peer_reply(8'h42, 40'h0102030405, 0, 2);
    repeat (10) @(negedge clk);
    vectors++;
    if (n_fe != fe0 + 1 || n_rv != rv0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL parity_error got fe=%0d rv=%0d busy=%b required 1 0 0", n_fe - fe0, n_rv - rv0, busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_response();
    test_timeout();
    test_frame_error();
    test_glitch();
    test_reset_abort();
`ifdef WIDE_UART_HOST_PARITY_EN
    test_parity();
`endif
    vectors++;
    if (exp_rsp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rsp_pending got %0d required 0", exp_rsp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
